// File: rtl/fdc_access_ctrl.sv
// -----------------------------------------------------------------------------
// fdc_access_ctrl
//
// Bridges CPU I/O cycles on the +3 FDC ports (#2FFD status, #3FFD data) to the
// FDC bus timing. Each accepted access is stretched into a fixed sequence:
// address/data setup, an active-low rd/wr strobe, and address/data hold. The
// controller then waits for the CPU to end its cycle and enforces a recovery
// gap before the next access can be accepted.
//
// Build option:
//   FDC_WAIT_EN  - when defined, cpu_wait_n is pulled low from the cycle after
//                  access start until the FSM leaves HOLD. When undefined,
//                  cpu_wait_n is tied high.
//
// Parameters (each of SETUP, HOLD and RECOVERY must be at least 1):
//   SETUP_CYCLES    - clk28 cycles of setup before the strobe
//   STROBE_CYCLES   - strobe low width in clk28 cycles (2..15)
//   HOLD_CYCLES     - clk28 cycles of hold after the strobe rises
//   RECOVERY_CYCLES - minimum idle cycles between consecutive strobes
//
// Ports:
//   clk28, rst_n       - clock and asynchronous active-low reset
//   cs, a12            - decoded FDC port select and register select address bit
//   cpu_rd, cpu_wr     - CPU I/O strobes, active-high
//   cpu_d              - CPU write data
//   d_out, d_out_active- captured read data and its bus-drive enable
//   cpu_wait_n         - active-low CPU WAIT request
//   fdc_a0             - FDC register select
//   fdc_rd_n, fdc_wr_n - FDC strobes, active-low
//   fdc_d_out, fdc_d_oe- data to the FDC and its output enable
//   fdc_d_in           - FDC read data
// -----------------------------------------------------------------------------
module fdc_access_ctrl #(
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 8,
    parameter int HOLD_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 3
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       a12,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_d,
    output logic [7:0] d_out,
    output logic       d_out_active,
    output logic       cpu_wait_n,
    output logic       fdc_a0,
    output logic       fdc_rd_n,
    output logic       fdc_wr_n,
    output logic [7:0] fdc_d_out,
    output logic       fdc_d_oe,
    input  logic [7:0] fdc_d_in
);

    // state   | meaning
    // --------+---------------------------------------------------------
    // IDLE    | waiting for a qualified CPU read/write of the FDC ports
    // SETUP   | address/data presented, strobe still high
    // STROBE  | fdc_rd_n or fdc_wr_n held low
    // HOLD    | strobe released, address/data still held
    // DONE    | waiting for the CPU to drop cpu_rd and cpu_wr
    // RECOVER | enforced idle gap before the next access
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } state_t;

    // Counters load N-1 on entry and the state ends when they reach zero.
    localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVERY_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       dir_wr;

    logic start_rd;
    logic start_wr;
    logic start;

    // Simultaneous rd+wr is rejected, as are writes to the status register.
    assign start_rd = cs && cpu_rd && !cpu_wr;
    assign start_wr = cs && cpu_wr && !cpu_rd && a12;
    assign start    = (state == IDLE) && (start_rd || start_wr);

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            dir_wr       <= 1'b0;
            fdc_rd_n     <= 1'b1;
            fdc_wr_n     <= 1'b1;
            fdc_d_oe     <= 1'b0;
            fdc_a0       <= 1'b0;
            fdc_d_out    <= 8'h00;
            d_out        <= 8'hFF;
            d_out_active <= 1'b0;
        end else begin
            // Bus drive ends once the CPU read strobe has gone away; a capture
            // in the same cycle below takes precedence.
            if (d_out_active && !cpu_rd) begin
                d_out_active <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (start) begin
                        state     <= SETUP;
                        cnt       <= SETUP_LAST;
                        fdc_a0    <= a12;
                        dir_wr    <= start_wr;
                        fdc_d_out <= cpu_d;
                        fdc_d_oe  <= start_wr;
                    end
                end

                SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LAST;
                        if (dir_wr) begin
                            fdc_wr_n <= 1'b0;
                        end else begin
                            fdc_rd_n <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                STROBE: begin
                    if (cnt == 4'd0) begin
                        state    <= HOLD;
                        cnt      <= HOLD_LAST;
                        fdc_rd_n <= 1'b1;
                        fdc_wr_n <= 1'b1;
                        if (!dir_wr) begin
                            d_out        <= fdc_d_in;
                            d_out_active <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                HOLD: begin
                    if (cnt == 4'd0) begin
                        state    <= DONE;
                        fdc_d_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    cnt <= 4'd0;
                    if (!cpu_rd && !cpu_wr) begin
                        state <= RECOVER;
                        cnt   <= RECOVER_LAST;
                    end
                end

                RECOVER: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= 4'd0;
                    fdc_rd_n <= 1'b1;
                    fdc_wr_n <= 1'b1;
                    fdc_d_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef FDC_WAIT_EN
    logic wait_q;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 1'b1;
        end else if (start) begin
            wait_q <= 1'b0;
        end else if (state == HOLD && cnt == 4'd0) begin
            wait_q <= 1'b1;
        end
    end

    assign cpu_wait_n = wait_q;
`else
    assign cpu_wait_n = 1'b1;
`endif

endmodule
